regfile_writeback: RTL

Writeback arbiter feeding the single write port of the CPU register file (`we`, `wr_addr`, `wr_data`). It merges two result producers: an always-accepted ALU stream and a handshaked load stream buffered in a 2-entry FIFO. It tracks per-register pending-load hazards for decode. After every reset it sweeps zeros into all registers before normal writeback begins.

---
 rtl/regfile_writeback.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and a 2-entry load queue onto the register file
// write port, zero-sweeping every register after reset and flagging pending loads.
module regfile_writeback #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [AW-1:0]        alu_addr,
  input  logic [BUS_WIDTH-1:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [AW-1:0]        ld_addr,
  input  logic [BUS_WIDTH-1:0] ld_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wr_addr,
  output logic [BUS_WIDTH-1:0] rf_wr_data,
  output logic [DEPTH-1:0]     pending,
  output logic                 init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0] vld_q, vld_d, live_q, live_d;
  logic [AW-1:0] ent_addr_q [2];
  logic [AW-1:0] ent_addr_d [2];
  logic [BUS_WIDTH-1:0] ent_data_q [2];
  logic [BUS_WIDTH-1:0] ent_data_d [2];
  logic rd_q, rd_d, wr_q, wr_d;
  logic we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic run, push;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      vld_q <= '0;
      live_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      live_q <= live_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end
  always_comb begin
    state_d = (state_q == INIT && cnt_q == AW'(DEPTH - 1)) ? RUN : state_q;
  end
  always_comb begin
    run = (state_q == RUN);
    ld_ready = run && !(&vld_q);
    init_done = run;
    rf_we = we_q;
    rf_wr_addr = waddr_q;
    rf_wr_data = wdata_q;
    pending = '0;
    for (int r = 0; r < DEPTH; r++)
      for (int i = 0; i < 2; i++)
        pending[r] = pending[r] | (vld_q[i] & live_q[i] & (ent_addr_q[i] == AW'(r)));
  end
  // ALU has priority; a younger ALU write kills older queued loads to the same register.
  always_comb begin
    cnt_d = cnt_q;
    vld_d = vld_q;
    live_d = live_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    rd_d = rd_q;
    wr_d = wr_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    push = ld_valid && ld_ready;
    if (!run) begin
      we_d = 1'b1;
      waddr_d = cnt_q;
      wdata_d = '0;
      cnt_d = cnt_q + 1'b1;
    end else if (alu_valid) begin
      we_d = 1'b1;
      waddr_d = alu_addr;
      wdata_d = alu_data;
      for (int i = 0; i < 2; i++)
        if (vld_q[i] && ent_addr_q[i] == alu_addr) live_d[i] = 1'b0;
    end else if (vld_q[rd_q]) begin
      we_d = live_q[rd_q];
      waddr_d = live_q[rd_q] ? ent_addr_q[rd_q] : waddr_q;
      wdata_d = live_q[rd_q] ? ent_data_q[rd_q] : wdata_q;
      vld_d[rd_q] = 1'b0;
      rd_d = ~rd_q;
    end
    if (push) begin
      vld_d[wr_q] = 1'b1;
      live_d[wr_q] = !(alu_valid && alu_addr == ld_addr);
      ent_addr_d[wr_q] = ld_addr;
      ent_data_d[wr_q] = ld_data;
      wr_d = ~wr_q;
    end
  end
endmodule
